// File: rtl/note_select.sv
// note_select: debounces seven raw note switches and publishes a registered,
// priority-encoded (lowest index wins) one-hot note selection.
//
// Ports
//   clk         : system clock, all logic on the rising edge
//   reset       : synchronous, active-high reset
//   switches[6:0]: raw asynchronous switches, bit0=C4 ... bit6=B4
//   notes[6:0]  : debounced one-hot selection (lowest set switch only)
//   note_idx    : index 0-6 of the selected note, 7 when none
//   note_valid  : high when notes is non-zero
//   note_change : one-cycle pulse in the cycle notes takes a new value
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive disagreeing cycles needed to accept a change
//   CNT_W           : per-switch debounce counter width
//
// Build option
//   NOTE_SUSTAIN_EN : when defined, releasing every switch keeps the last
//                     selection on notes/note_idx/note_valid with no pulse.

// Per-switch synchronizer plus debounce counter.
module note_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // DEBOUNCE_CYCLES consecutive disagreements (counts 0..LAST): accept
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module note_select #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] switches,
  output logic [6:0] notes,
  output logic [2:0] note_idx,
  output logic       note_valid,
  output logic       note_change
);
  localparam int NUM_SW = 7;

  // The counter must reach DEBOUNCE_CYCLES-1 without wrapping.
  generate
    if (DEBOUNCE_CYCLES < 2 || (longint'(DEBOUNCE_CYCLES) >> CNT_W) != 0) begin : gBadParam
      $error("note_select: DEBOUNCE_CYCLES must be >= 2 and < 2**CNT_W");
    end
  endgenerate

  logic [NUM_SW-1:0] deb;

  generate
    for (genvar i = 0; i < NUM_SW; i++) begin : gLane
      note_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) uDeb (
        .clk  (clk),
        .reset(reset),
        .raw  (switches[i]),
        .deb  (deb[i])
      );
    end
  endgenerate

  // Lowest-index debounced bit wins; scanning downward lets it overwrite.
  logic [NUM_SW-1:0] nextNotes;
  logic [2:0]        nextIdx;

  always_comb begin
    nextNotes = '0;
    nextIdx   = 3'd7;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (deb[i]) begin
        nextNotes    = '0;
        nextNotes[i] = 1'b1;
        nextIdx      = 3'(i);
      end
    end
  end

  // Outputs register together so idx/valid always match notes; the change
  // pulse compares against the value notes is about to leave.
  always_ff @(posedge clk) begin
    if (reset) begin
      notes       <= '0;
      note_idx    <= 3'd7;
      note_valid  <= 1'b0;
      note_change <= 1'b0;
    end else begin
`ifdef NOTE_SUSTAIN_EN
      if (deb != '0) begin
        notes      <= nextNotes;
        note_idx   <= nextIdx;
        note_valid <= 1'b1;
      end
      note_change <= (deb != '0) && (nextNotes != notes);
`else
      notes       <= nextNotes;
      note_idx    <= nextIdx;
      note_valid  <= (deb != '0);
      note_change <= (nextNotes != notes);
`endif
    end
  end
endmodule

// File: tb/tb_note_select.sv
// Bench for note_select with DEBOUNCE_CYCLES=8: directed scenarios plus a
// randomized run, all checked against a history-window reference model.
module tb_note_select;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] switches;
  logic [6:0] notes;
  logic [2:0] note_idx;
  logic       note_valid;
  logic       note_change;

  always #5 clk = ~clk;

  note_select #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .switches   (switches),
    .notes      (notes),
    .note_idx   (note_idx),
    .note_valid (note_valid),
    .note_change(note_change)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: a switch's accepted state flips once the last D values
  // the debouncer saw (raw delayed by two edges) all disagree with it.
  logic [6:0] rawQ[$];
  logic [6:0] seenQ[$];
  logic [6:0] mDeb;
  logic [6:0] expNotes;
  logic [2:0] expIdx;
  logic       expValid;
  logic       expChange;

  task automatic modelEdge(input logic [6:0] raw, input logic rst);
    logic [6:0] sel;
    logic [2:0] idx;
    logic [6:0] seen;
    logic       allDiff;
    if (rst) begin
      rawQ.delete();
      seenQ.delete();
      mDeb = '0; expNotes = '0; expIdx = 3'd7; expValid = 1'b0; expChange = 1'b0;
      return;
    end
    sel = '0; idx = 3'd7;
    for (int b = 0; b < 7; b++)
      if (mDeb[b] && sel == '0) begin sel[b] = 1'b1; idx = 3'(b); end
`ifdef NOTE_SUSTAIN_EN
    expChange = (sel != '0) && (sel != expNotes);
    if (sel != '0) begin expNotes = sel; expIdx = idx; expValid = 1'b1; end
`else
    expChange = (sel != expNotes);
    expNotes = sel; expIdx = idx; expValid = (sel != '0);
`endif
    rawQ.push_back(raw);
    seen = (rawQ.size() >= 3) ? rawQ[rawQ.size()-3] : 7'd0;
    if (rawQ.size() > 3) void'(rawQ.pop_front());
    seenQ.push_back(seen);
    if (seenQ.size() > D) void'(seenQ.pop_front());
    if (seenQ.size() == D)
      for (int b = 0; b < 7; b++) begin
        allDiff = 1'b1;
        foreach (seenQ[k]) if (seenQ[k][b] == mDeb[b]) allDiff = 1'b0;
        if (allDiff) mDeb[b] = ~mDeb[b];
      end
  endtask

  task automatic tick(input logic [6:0] sw, input logic rst);
    @(negedge clk);
    switches = sw;
    reset    = rst;
    @(posedge clk);
    modelEdge(sw, rst);
    #1;
  endtask

  task automatic test_reset();
    tick(7'h7f, 1'b1);
    tick(7'h00, 1'b1);
    vecs++;
    if ({notes, note_idx, note_valid, note_change} !== {7'd0, 3'd7, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset: got notes=%b idx=%0d valid=%b chg=%b, want 0000000/7/0/0",
               notes, note_idx, note_valid, note_change);
    end
  endtask

  task automatic test_latency();
    for (int e = 1; e <= 13; e++) begin
      tick(7'b0000100, 1'b0);
      vecs++;
      if ({notes, note_idx, note_valid, note_change} !== {expNotes, expIdx, expValid, expChange}) begin
        errs++;
        $display("FAIL latency model e=%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 notes, note_idx, note_valid, note_change, expNotes, expIdx, expValid, expChange);
      end
      vecs++;
      if ({notes, note_idx, note_change} !== {(e >= 11) ? 7'b0000100 : 7'd0,
                                             (e >= 11) ? 3'd2 : 3'd7, e == 11}) begin
        errs++;
        $display("FAIL latency edge %0d: got notes=%b idx=%0d chg=%b", e, notes, note_idx, note_change);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    tick(7'd0, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick((e <= 7) ? 7'b0000001 : 7'd0, 1'b0);
      pulses += note_change;
      vecs++;
      if ({notes, note_idx, note_valid, note_change} !== {expNotes, expIdx, expValid, expChange}) begin
        errs++;
        $display("FAIL glitch model e=%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 notes, note_idx, note_valid, note_change, expNotes, expIdx, expValid, expChange);
      end
    end
    vecs++;
    if (pulses != 0 || notes !== 7'd0) begin
      errs++;
      $display("FAIL glitch: pulses=%0d notes=%b, want 0 and 0000000", pulses, notes);
    end
  endtask

  task automatic test_priority();
    logic [6:0] pat[3]  = '{7'b1000000, 7'b1000010, 7'b1000000};
    logic [6:0] want[3] = '{7'b1000000, 7'b0000010, 7'b1000000};
    logic [2:0] wIdx[3] = '{3'd6, 3'd1, 3'd6};
    int pulses = 0;
    tick(7'd0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int e = 0; e < 14; e++) begin
        tick(pat[p], 1'b0);
        pulses += note_change;
        vecs++;
        if ({notes, note_idx, note_valid, note_change} !== {expNotes, expIdx, expValid, expChange}) begin
          errs++;
          $display("FAIL priority model p=%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", p,
                   notes, note_idx, note_valid, note_change, expNotes, expIdx, expValid, expChange);
        end
      end
      vecs++;
      if (notes !== want[p] || note_idx !== wIdx[p]) begin
        errs++;
        $display("FAIL priority phase %0d: got %b/%0d want %b/%0d", p, notes, note_idx, want[p], wIdx[p]);
      end
    end
    vecs++;
    if (pulses != 3) begin
      errs++;
      $display("FAIL priority pulses: got %0d want 3", pulses);
    end
  endtask

  task automatic test_simul();
    int pulses = 0;
    tick(7'd0, 1'b1);
    for (int e = 0; e < 16; e++) begin
      tick((e < 3) ? 7'd0 : 7'b0101000, 1'b0);
      pulses += note_change;
      vecs++;
      if ({notes, note_idx, note_valid, note_change} !== {expNotes, expIdx, expValid, expChange}) begin
        errs++;
        $display("FAIL simul model e=%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 notes, note_idx, note_valid, note_change, expNotes, expIdx, expValid, expChange);
      end
    end
    vecs++;
    if (pulses != 1 || notes !== 7'b0001000 || note_idx !== 3'd3) begin
      errs++;
      $display("FAIL simul: pulses=%0d notes=%b idx=%0d, want 1/0001000/3", pulses, notes, note_idx);
    end
  endtask

  task automatic test_reset_mid();
    tick(7'd0, 1'b1);
    for (int e = 1; e <= 7; e++) tick(7'b0010000, 1'b0);  // counter reaches 5
    tick(7'b0010000, 1'b1);
    vecs++;
    if ({notes, note_idx, note_valid, note_change} !== {7'd0, 3'd7, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_mid in reset: got %b/%0d/%b/%b", notes, note_idx, note_valid, note_change);
    end
    for (int e = 1; e <= 12; e++) begin
      tick(7'b0010000, 1'b0);
      vecs++;
      if ({notes, note_idx, note_valid, note_change} !== {expNotes, expIdx, expValid, expChange}) begin
        errs++;
        $display("FAIL reset_mid model e=%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 notes, note_idx, note_valid, note_change, expNotes, expIdx, expValid, expChange);
      end
      vecs++;
      if (notes !== ((e >= 11) ? 7'b0010000 : 7'd0)) begin
        errs++;
        $display("FAIL reset_mid edge %0d: got notes=%b", e, notes);
      end
    end
  endtask

  task automatic test_release();
    int pulses = 0;
    for (int e = 1; e <= 14; e++) begin
      tick(7'd0, 1'b0);
      pulses += note_change;
      vecs++;
      if ({notes, note_idx, note_valid, note_change} !== {expNotes, expIdx, expValid, expChange}) begin
        errs++;
        $display("FAIL release model e=%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", e,
                 notes, note_idx, note_valid, note_change, expNotes, expIdx, expValid, expChange);
      end
`ifdef NOTE_SUSTAIN_EN
      vecs++;
      if (notes !== 7'b0010000 || note_valid !== 1'b1 || note_change !== 1'b0) begin
        errs++;
        $display("FAIL release sustain edge %0d: got %b/%b/%b", e, notes, note_valid, note_change);
      end
`else
      vecs++;
      if (notes !== ((e >= 11) ? 7'd0 : 7'b0010000) || note_change !== (e == 11)) begin
        errs++;
        $display("FAIL release edge %0d: got notes=%b chg=%b", e, notes, note_change);
      end
`endif
    end
    vecs++;
`ifdef NOTE_SUSTAIN_EN
    if (pulses != 0) begin
`else
    if (pulses != 1 || note_idx !== 3'd7 || note_valid !== 1'b0) begin
`endif
      errs++;
      $display("FAIL release summary: pulses=%0d idx=%0d valid=%b", pulses, note_idx, note_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0] sw;
    int hold;
    tick(7'd0, 1'b1);
    for (int seg = 0; seg < 120; seg++) begin
      sw   = 7'($urandom);
      if ($urandom_range(0, 2) == 0) sw = sw & 7'($urandom);
      hold = $urandom_range(1, 14);
      for (int e = 0; e < hold; e++) begin
        tick(sw, ($urandom_range(0, 99) == 0));
        vecs++;
        if ({notes, note_idx, note_valid, note_change} !== {expNotes, expIdx, expValid, expChange}) begin
          errs++;
          $display("FAIL random seg=%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", seg,
                   notes, note_idx, note_valid, note_change, expNotes, expIdx, expValid, expChange);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    switches = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_priority();
    test_simul();
    test_reset_mid();
    test_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
